fp_div_gen: RTL and testbench
=============================

# fp_div_gen

Parametrised IEEE-754 floating-point divider: the next generation of the fixed binary64 divider. Supports any binary format via exponent/fraction width parameters, four rounding modes, a valid/ready handshake on both sides, and full IEEE exception flags. It sits in the calculator datapath beside the add/mul units and shares the decomposer/recomposer conventions.

## Interface
- `EXP_W`, default 11: exponent field width (8 gives binary32).
- `FRAC_W`, default 52: stored fraction width (23 gives binary32).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high. The clock and reset are fixed as one clock with an asynchronous active-high reset.
- `in_valid`  in  1  operands and `rm` present.
- `in_ready`  out  1  high only in IDLE.
- `fp_a`, `fp_b`  in  1+EXP_W+FRAC_W  dividend and divisor.
- `rm`  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (−inf).
- `out_valid`  out  1  result and flags valid; held until accepted.
- `out_ready`  in  1  consumer accepts.
- `fp_out`  out  1+EXP_W+FRAC_W  quotient.
- `flags`  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

## Operation
- Capture `fp_a`, `fp_b`, `rm` on `in_valid & in_ready`.
- States: IDLE → PREP → DIV → NORM → DENORM → ROUND → PACK → HOLD → IDLE.
- PREP: classify. Any NaN → canonical qNaN (sign 0, exp all-ones, frac MSB 1); invalid is set if either input is an sNaN, or for 0/0 or inf/inf. Finite nonzero/0 → inf with sign a^b and div_by_zero. inf/finite → inf. 0/nonzero or finite/inf → signed zero. All specials jump to PACK.
- DIV: restoring division, one quotient bit per cycle, FRAC_W+4 iterations: hidden bit, fraction, and G, R, S bits. Remainder is nonzero → sticky. Exponent is computed as ea−eb in an EXP_W+3-bit signed value.
- NORM: if the quotient MSB is 0, shift left 1 and decrement the exponent.
- DENORM: if the exponent is below emin, right-shift by (emin−exp), with shifted-out bits ORed into sticky, and set exp=emin−1. Shifts saturate at FRAC_W+3.
- ROUND: increment per `rm` using LSB/G/R/S and sign. A carry renormalises the significand and increments the exponent. inexact = G|R|S.
- PACK: if exp > emax → overflow+inexact. The result is inf for RNE, for RUP when positive, and for RDN when negative; otherwise it is max finite. Underflow = tiny (pre-rounding) & inexact.
- HOLD: `out_valid`=1. Outputs are stable until `out_ready`, then the block returns to IDLE with `out_valid` low.
- Reset (any time) → IDLE. All outputs are 0 except `in_ready`, which is 1 after reset is released. An in-flight operation is discarded.

## Timing
- Handshake in cycle 0.
- Finite/finite: `out_valid` rises at cycle FRAC_W+10 (62 for binary64, 33 for binary32). This is fixed regardless of data or configuration.
- Special cases: `out_valid` rises at cycle 3.
- Back-to-back: a new accept is possible the cycle after the out handshake. `in_ready` is low from accept until then.
- `out_ready` held high: HOLD lasts exactly one cycle.

## Configuration
- `FP_DIV_GEN_SUBNORMAL_EN` defined: subnormal inputs are normalised in PREP with a leading-zero count and exponent adjust (same cycle count). Subnormal results are produced through DENORM (gradual underflow).
- Undefined: subnormal inputs are treated as signed zero (DAZ). DENORM is a pass-through stage. Tiny results flush to signed zero with underflow+inexact. Latency is unchanged.

## Structure
- Package `fp_div_gen_pkg`: rounding-mode enum, state enum, flag bit indices, and width helper functions (bias, emin, emax derived from EXP_W).
- Sub-module `fp_round_mode`: combinational; takes significand, G, R, S, sign, and `rm`; outputs the rounded significand, carry, and inexact. It is reused by the adder and multiplier later.

## Test plan
- Basic divide, binary64, RNE: 0x4018000000000000 / 0x4000000000000000 → 0x4008000000000000, flags 0, `out_valid` at cycle 62.
- Rounding modes: 0x3FF0000000000000 / 0x4008000000000000 (1/3) → RNE 0x3FD5555555555555 and RUP 0x3FD5555555555556, inexact set in both.
- Specials: 1.0/+0 → 0x7FF0000000000000 with div_by_zero. 0/0 → 0x7FF8000000000000 with invalid, at cycle 3.
- Overflow: 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 → RNE 0x7FF0000000000000 and RTZ 0x7FEFFFFFFFFFFFFF, overflow+inexact.
- Subnormal: 0x0010000000000000 / 0x4000000000000000.
  - With the macro: 0x0008000000000000, no flags.
  - Without the macro: 0x0000000000000000 with underflow+inexact.
- Handshake: hold `out_ready`=0 for 10 cycles → output is stable and `in_ready` stays 0. Assert `rst` mid-DIV → next cycle `out_valid`=0 and `flags`=0, then `in_ready`=1 after release. Repeat the basic divide with EXP_W=8, FRAC_W=23: 6.0f/2.0f → 0x40400000 at cycle 33.

Source files
------------

// File: rtl/fp_div_gen_pkg.sv
// Shared types and width helpers for the parametrised FP divider.
// Rounding modes, FSM encodings, flag bit positions, exponent bounds.
package fp_div_gen_pkg;

   typedef enum logic [1:0] {
      RM_RNE = 2'd0,
      RM_RTZ = 2'd1,
      RM_RUP = 2'd2,
      RM_RDN = 2'd3
   } rm_e;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PREP   = 3'd1;
   localparam logic [2:0] S_DIV    = 3'd2;
   localparam logic [2:0] S_NORM   = 3'd3;
   localparam logic [2:0] S_DENORM = 3'd4;
   localparam logic [2:0] S_ROUND  = 3'd5;
   localparam logic [2:0] S_PACK   = 3'd6;
   localparam logic [2:0] S_HOLD   = 3'd7;

   localparam int FLG_NV = 4;
   localparam int FLG_DZ = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_emin(input int exp_w);
      return 1 - fp_bias(exp_w);
   endfunction

   function automatic int fp_emax(input int exp_w);
      return fp_bias(exp_w);
   endfunction

endpackage

// File: rtl/fp_div_gen_round.sv
// fp_round_mode: rounds a significand using guard/round/sticky bits.
// Purely combinational; shared by the divide, add and multiply units.
module fp_round_mode
   import fp_div_gen_pkg::*;
#(
   parameter int SIG_W = 53
) (
   input  logic [SIG_W-1:0] sig,
   input  logic             g,
   input  logic             r,
   input  logic             s,
   input  logic             sign,
   input  logic [1:0]       rm,
   output logic [SIG_W-1:0] sig_out,
   output logic             carry,
   output logic             inexact
);

   logic inc;
   logic any;

   // Decide the increment from the mode, then add it in.
   always_comb begin
      inc = 1'b0;
      any = g | r | s;
      unique case (rm_e'(rm))
         RM_RNE:  inc = g & (r | s | sig[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RUP:  inc = ~sign & any;
         RM_RDN:  inc = sign & any;
         default: inc = 1'b0;
      endcase
      {carry, sig_out} = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
      inexact = any;
   end

endmodule

// File: rtl/fp_div_gen.sv
// fp_div_gen: multi-cycle IEEE-754 divider, restoring, one bit per cycle.
// FP_DIV_GEN_SUBNORMAL_EN enables subnormal inputs/results (else DAZ/FTZ).
module fp_div_gen
   import fp_div_gen_pkg::*;
#(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [EXP_W+FRAC_W:0]     fp_a,
   input  logic [EXP_W+FRAC_W:0]     fp_b,
   input  logic [1:0]                rm,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [EXP_W+FRAC_W:0]     fp_out,
   output logic [4:0]                flags
);

   localparam int W  = 1 + EXP_W + FRAC_W;
   localparam int XW = EXP_W + 3;
   localparam int QW = FRAC_W + 4;
   localparam int CW = $clog2(QW + 1);

   localparam logic signed [XW-1:0] ONE_X  = XW'(1);
   localparam logic signed [XW-1:0] BIAS_X = XW'(fp_bias(EXP_W));
   localparam logic signed [XW-1:0] EMIN_X = XW'(fp_emin(EXP_W) + fp_bias(EXP_W));
   localparam logic signed [XW-1:0] EMAX_X = XW'(fp_emax(EXP_W) + fp_bias(EXP_W));
   localparam logic signed [XW-1:0] DEN_X  = XW'(fp_emin(EXP_W) + fp_bias(EXP_W) - 1);
   localparam logic [CW-1:0]        LAST   = CW'(QW - 1);

   logic [2:0]             state;
   logic [W-1:0]           a_r, b_r;
   logic [1:0]             rm_r;
   logic                   sign_r;
   logic signed [XW-1:0]   exp_r;
   logic [FRAC_W+1:0]      rem_r;
   logic [FRAC_W:0]        mb_r;
   logic [QW-1:0]          q_r;
   logic [CW-1:0]          cnt_r;
   logic                   sticky_r, tiny_r, inexact_r, special_r;
   logic [FRAC_W-1:0]      frac_r;
   logic [W-1:0]           spec_out_r;
   logic [4:0]             spec_flg_r;

   logic                   sa, sb;
   logic [EXP_W-1:0]       ea, eb;
   logic [FRAC_W-1:0]      fa, fb;
   logic                   a_nan, b_nan, a_snan, b_snan;
   logic                   a_inf, b_inf, a_zero, b_zero;
   logic [FRAC_W:0]        sig_a, sig_b;
   logic signed [XW-1:0]   xa, xb, exp_q;
   logic                   spec_hit;
   logic [W-1:0]           spec_val;
   logic [4:0]             spec_flg;
   logic                   rem_ge;
   logic [FRAC_W+1:0]      rem_keep, rem_nx;
   logic                   tiny_c;
   logic [FRAC_W:0]        rnd_sig;
   logic                   rnd_cy, rnd_nx;
   logic [W-1:0]           pack_out;
   logic [4:0]             pack_flg;
   logic                   ovf_inf;

   assign {sa, ea, fa} = a_r;
   assign {sb, eb, fb} = b_r;

   assign a_nan  = (&ea) & (|fa);
   assign b_nan  = (&eb) & (|fb);
   assign a_snan = a_nan & ~fa[FRAC_W-1];
   assign b_snan = b_nan & ~fb[FRAC_W-1];
   assign a_inf  = (&ea) & ~(|fa);
   assign b_inf  = (&eb) & ~(|fb);

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_HOLD);

`ifdef FP_DIV_GEN_SUBNORMAL_EN
   assign a_zero = ~(|ea) & ~(|fa);
   assign b_zero = ~(|eb) & ~(|fb);

   function automatic logic [XW-1:0] lzc(input logic [FRAC_W:0] v);
      logic [XW-1:0] c;
      logic          hit;
      c   = '0;
      hit = 1'b0;
      for (int i = FRAC_W; i >= 0; i--) begin
         if (v[i]) hit = 1'b1;
         else if (!hit) c = c + XW'(1);
      end
      return c;
   endfunction

   logic [XW-1:0] lz_a, lz_b;

   // Normalise subnormal operands so the hidden bit is always set.
   always_comb begin
      lz_a  = lzc({1'b0, fa});
      lz_b  = lzc({1'b0, fb});
      sig_a = {1'b1, fa};
      sig_b = {1'b1, fb};
      xa    = {3'b000, ea};
      xb    = {3'b000, eb};
      if (ea == '0) begin
         sig_a = {1'b0, fa} << lz_a;
         xa    = ONE_X - lz_a;
      end
      if (eb == '0) begin
         sig_b = {1'b0, fb} << lz_b;
         xb    = ONE_X - lz_b;
      end
   end

   localparam logic signed [XW-1:0] SAT_X = XW'(FRAC_W + 3);
   logic signed [XW-1:0] dsh;
   logic [XW-1:0]        sh;
   logic [2*QW-1:0]      ext;

   // Right-shift amount into the subnormal range, saturated.
   always_comb begin
      dsh = EMIN_X - exp_r;
      sh  = (dsh > SAT_X) ? SAT_X : dsh;
      ext = {q_r, {QW{1'b0}}} >> sh;
   end
`else
   assign a_zero = ~(|ea);
   assign b_zero = ~(|eb);

   // Subnormal operands never reach here: they classify as zero.
   always_comb begin
      sig_a = {1'b1, fa};
      sig_b = {1'b1, fb};
      xa    = {3'b000, ea};
      xb    = {3'b000, eb};
   end
`endif

   assign exp_q  = xa - xb + BIAS_X;
   assign tiny_c = exp_r < EMIN_X;

   // Special operand classification, in IEEE priority order.
   always_comb begin
      spec_hit = 1'b1;
      spec_val = '0;
      spec_flg = '0;
      if (a_nan | b_nan) begin
         spec_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
         spec_flg[FLG_NV] = a_snan | b_snan;
      end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
         spec_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
         spec_flg[FLG_NV] = 1'b1;
      end else if (a_inf) begin
         spec_val = {sa ^ sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (b_zero) begin
         spec_val = {sa ^ sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         spec_flg[FLG_DZ] = 1'b1;
      end else if (a_zero | b_inf) begin
         spec_val = {sa ^ sb, {(W-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // One restoring-division step.
   always_comb begin
      rem_ge   = rem_r >= {1'b0, mb_r};
      rem_keep = rem_ge ? (rem_r - {1'b0, mb_r}) : rem_r;
      rem_nx   = rem_keep << 1;
   end

   fp_round_mode #(.SIG_W(FRAC_W + 1)) u_round (
      .sig     (q_r[QW-1:3]),
      .g       (q_r[2]),
      .r       (q_r[1]),
      .s       (q_r[0] | sticky_r),
      .sign    (sign_r),
      .rm      (rm_r),
      .sig_out (rnd_sig),
      .carry   (rnd_cy),
      .inexact (rnd_nx)
   );

   // Final result selection: special, overflow, flush or normal pack.
   always_comb begin
      ovf_inf  = (rm_e'(rm_r) == RM_RNE)
               | ((rm_e'(rm_r) == RM_RUP) & ~sign_r)
               | ((rm_e'(rm_r) == RM_RDN) & sign_r);
      pack_out = {sign_r, exp_r[EXP_W-1:0], frac_r};
      pack_flg = '0;
      pack_flg[FLG_NX] = inexact_r;
      pack_flg[FLG_UF] = tiny_r & inexact_r;
      if (special_r) begin
         pack_out = spec_out_r;
         pack_flg = spec_flg_r;
      end else if (exp_r > EMAX_X) begin
         pack_out = ovf_inf
                  ? {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                  : {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
         pack_flg = '0;
         pack_flg[FLG_OF] = 1'b1;
         pack_flg[FLG_NX] = 1'b1;
`ifndef FP_DIV_GEN_SUBNORMAL_EN
      end else if (tiny_r) begin
         pack_out = {sign_r, {(W-1){1'b0}}};
         pack_flg = '0;
         pack_flg[FLG_UF] = 1'b1;
         pack_flg[FLG_NX] = 1'b1;
`endif
      end
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         a_r        <= '0;
         b_r        <= '0;
         rm_r       <= '0;
         sign_r     <= 1'b0;
         exp_r      <= '0;
         rem_r      <= '0;
         mb_r       <= '0;
         q_r        <= '0;
         cnt_r      <= '0;
         sticky_r   <= 1'b0;
         tiny_r     <= 1'b0;
         inexact_r  <= 1'b0;
         special_r  <= 1'b0;
         frac_r     <= '0;
         spec_out_r <= '0;
         spec_flg_r <= '0;
         fp_out     <= '0;
         flags      <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_r   <= fp_a;
                  b_r   <= fp_b;
                  rm_r  <= rm;
                  state <= S_PREP;
               end
            end
            S_PREP: begin
               sign_r     <= sa ^ sb;
               exp_r      <= exp_q;
               rem_r      <= {1'b0, sig_a};
               mb_r       <= sig_b;
               q_r        <= '0;
               cnt_r      <= '0;
               sticky_r   <= 1'b0;
               special_r  <= spec_hit;
               spec_out_r <= spec_val;
               spec_flg_r <= spec_flg;
               state      <= spec_hit ? S_PACK : S_DIV;
            end
            S_DIV: begin
               rem_r <= rem_nx;
               q_r   <= {q_r[QW-2:0], rem_ge};
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == LAST) state <= S_NORM;
            end
            S_NORM: begin
               if (!q_r[QW-1]) begin
                  q_r   <= q_r << 1;
                  exp_r <= exp_r - ONE_X;
               end
               sticky_r <= |rem_r;
               state    <= S_DENORM;
            end
            S_DENORM: begin
               tiny_r <= tiny_c;
`ifdef FP_DIV_GEN_SUBNORMAL_EN
               if (tiny_c) begin
                  q_r      <= ext[2*QW-1:QW];
                  sticky_r <= sticky_r | (|ext[QW-1:0]);
                  exp_r    <= DEN_X;
               end
`endif
               state <= S_ROUND;
            end
            S_ROUND: begin
               inexact_r <= rnd_nx;
               if (rnd_cy) begin
                  frac_r <= '0;
                  exp_r  <= exp_r + ONE_X;
               end else begin
                  frac_r <= rnd_sig[FRAC_W-1:0];
                  if ((exp_r == DEN_X) && rnd_sig[FRAC_W]) exp_r <= EMIN_X;
               end
               state <= S_PACK;
            end
            S_PACK: begin
               fp_out <= pack_out;
               flags  <= pack_flg;
               state  <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_gen.sv
// Directed bench for fp_div_gen: binary64 and binary32 instances,
// vector table plus handshake stall and mid-operation reset sequences.
module tb_fp_div_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv64, ir64, ov64, or64;
   logic [63:0] a64, b64, o64;
   logic [1:0]  rm64;
   logic [4:0]  f64;
   logic        iv32, ir32, ov32, or32;
   logic [31:0] a32, b32, o32;
   logic [1:0]  rm32;
   logic [4:0]  f32;

   fp_div_gen u64 (
      .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
      .fp_a(a64), .fp_b(b64), .rm(rm64), .out_valid(ov64),
      .out_ready(or64), .fp_out(o64), .flags(f64)
   );

   fp_div_gen #(.EXP_W(8), .FRAC_W(23)) u32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .fp_a(a32), .fp_b(b32), .rm(rm32), .out_valid(ov32),
      .out_ready(or32), .fp_out(o32), .flags(f32)
   );

   typedef struct {
      string       name;
      bit          is32;
      logic [63:0] a;
      logic [63:0] b;
      logic [1:0]  rm;
      logic [63:0] res;
      logic [4:0]  flg;
      int          cyc;
   } vec_t;

   vec_t vt[14];
   int   n_pass = 0;
   int   n_tot  = 0;

   function automatic vec_t mk(string nm, bit s, logic [63:0] a,
                               logic [63:0] b, logic [1:0] rm,
                               logic [63:0] res, logic [4:0] flg, int cyc);
      vec_t v;
      v.name = nm; v.is32 = s; v.a = a; v.b = b; v.rm = rm;
      v.res = res; v.flg = flg; v.cyc = cyc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      @(negedge clk);
      if (v.is32) begin
         a32 = v.a[31:0]; b32 = v.b[31:0]; rm32 = v.rm; iv32 = 1'b1;
      end else begin
         a64 = v.a; b64 = v.b; rm64 = v.rm; iv64 = 1'b1;
      end
      chk({v.name, " in_ready"}, v.is32 ? ir32 : ir64, 1);
      @(posedge clk);
      #1;
      iv32 = 1'b0;
      iv64 = 1'b0;
      n = 1;
      while (!(v.is32 ? ov32 : ov64) && n < 150) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({v.name, " out_valid"}, v.is32 ? ov32 : ov64, 1);
      chk({v.name, " cycle"}, 64'(n), 64'(v.cyc));
      chk({v.name, " fp_out"}, v.is32 ? {32'h0, o32} : o64, v.res);
      chk({v.name, " flags"}, v.is32 ? f32 : f64, v.flg);
      @(posedge clk);
      #1;
      chk({v.name, " idle"},
          v.is32 ? {ov32, ir32} : {ov64, ir64}, 2'b01);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      iv64 = 1'b0; a64 = '0; b64 = '0; rm64 = '0; or64 = 1'b1;
      iv32 = 1'b0; a32 = '0; b32 = '0; rm32 = '0; or32 = 1'b1;

      vt[0]  = mk("div6_2", 0, 64'h4018000000000000, 64'h4000000000000000,
                  2'd0, 64'h4008000000000000, 5'h00, 62);
      vt[1]  = mk("third_rne", 0, 64'h3FF0000000000000, 64'h4008000000000000,
                  2'd0, 64'h3FD5555555555555, 5'h01, 62);
      vt[2]  = mk("third_rup", 0, 64'h3FF0000000000000, 64'h4008000000000000,
                  2'd2, 64'h3FD5555555555556, 5'h01, 62);
      vt[3]  = mk("third_rtz", 0, 64'h3FF0000000000000, 64'h4008000000000000,
                  2'd1, 64'h3FD5555555555555, 5'h01, 62);
      vt[4]  = mk("negthird_rdn", 0, 64'hBFF0000000000000, 64'h4008000000000000,
                  2'd3, 64'hBFD5555555555556, 5'h01, 62);
      vt[5]  = mk("one_zero", 0, 64'h3FF0000000000000, 64'h0,
                  2'd0, 64'h7FF0000000000000, 5'h08, 3);
      vt[6]  = mk("zero_zero", 0, 64'h0, 64'h0,
                  2'd0, 64'h7FF8000000000000, 5'h10, 3);
      vt[7]  = mk("snan", 0, 64'h7FF0000000000001, 64'h3FF0000000000000,
                  2'd0, 64'h7FF8000000000000, 5'h10, 3);
      vt[8]  = mk("inf_two", 0, 64'h7FF0000000000000, 64'h4000000000000000,
                  2'd0, 64'h7FF0000000000000, 5'h00, 3);
      vt[9]  = mk("ovf_rne", 0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000,
                  2'd0, 64'h7FF0000000000000, 5'h05, 62);
      vt[10] = mk("ovf_rtz", 0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000,
                  2'd1, 64'h7FEFFFFFFFFFFFFF, 5'h05, 62);
`ifdef FP_DIV_GEN_SUBNORMAL_EN
      vt[11] = mk("subnormal", 0, 64'h0010000000000000, 64'h4000000000000000,
                  2'd0, 64'h0008000000000000, 5'h00, 62);
`else
      vt[11] = mk("subnormal", 0, 64'h0010000000000000, 64'h4000000000000000,
                  2'd0, 64'h0000000000000000, 5'h03, 62);
`endif
      vt[12] = mk("f32_div6_2", 1, 64'h40C00000, 64'h40000000,
                  2'd0, 64'h40400000, 5'h00, 33);
      vt[13] = mk("f32_third", 1, 64'h3F800000, 64'h40400000,
                  2'd0, 64'h3EAAAAAB, 5'h01, 33);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset ctl64", {ov64, ir64}, 2'b01);
      chk("reset out64", {f64, o64[58:0]}, 64'h0);
      chk("reset sign64", o64[63:59], 5'h0);
      chk("reset ctl32", {ov32, ir32, f32, o32}, {2'b01, 37'h0});

      for (int i = 0; i < 14; i++) run_vec(vt[i]);

      @(negedge clk);
      a64 = 64'h3FF0000000000000; b64 = 64'h4008000000000000;
      rm64 = 2'd0; iv64 = 1'b1; or64 = 1'b0;
      @(posedge clk);
      #1;
      iv64 = 1'b0;
      n = 1;
      while (!ov64 && n < 150) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("stall valid", ov64, 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("stall out", o64, 64'h3FD5555555555555);
         chk("stall ctl", {ov64, ir64, f64}, {1'b1, 1'b0, 5'h01});
      end
      @(negedge clk);
      or64 = 1'b1;
      @(posedge clk);
      #1;
      chk("stall release", {ov64, ir64}, 2'b01);

      @(negedge clk);
      a64 = 64'h4018000000000000; b64 = 64'h4000000000000000;
      iv64 = 1'b1;
      @(posedge clk);
      #1;
      iv64 = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst mid valid+flags", {ov64, f64}, 6'h0);
      chk("rst mid fp_out", o64, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst release ready", {ov64, ir64}, 2'b01);
      repeat (70) @(posedge clk);
      #1;
      chk("rst discarded", {ov64, ir64}, 2'b01);

      run_vec(vt[0]);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
